// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory, its loader and the fetch path.
//   - Geometry constants: byte address width, memory size, word width and
//     the number of bytes per word.
//   - Loader FSM state encoding.
//   - byte_of(): little-endian byte lane extraction (lane 0 = bits 7:0).
package imem_pkg;

  localparam int ADDR_W         = 5;
  localparam int MEM_BYTES      = 32;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // Byte lane idx of a word, little-endian.
  function automatic logic [7:0] byte_of(input logic [WORD_W-1:0] word,
                                         input logic [1:0]        idx);
    byte_of = 8'(word >> {idx, 3'b000});
  endfunction

endpackage

// File: rtl/imem_loader.sv
// imem_loader: writes a stream of instruction words into the byte-wide write
// port of the instruction memory, four little-endian byte writes per word,
// while holding the CPU stalled.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   start, base_addr        begin a session at word-aligned base_addr
//   in_valid/in_word/in_last, in_ready   word input stream (no buffering)
//   mem_we/mem_addr/mem_wdata            byte write port of the memory
//   busy, cpu_stall         session active (LOAD or WRITE)
//   done                    one-cycle pulse when the session ends
//   overflow                sticky: last session filled memory before in_last
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W    = imem_pkg::ADDR_W,
  parameter int MEM_BYTES = imem_pkg::MEM_BYTES,
  parameter int WORD_W    = imem_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cpu_stall,
  output logic              done,
  output logic              overflow
);

  state_e            state_r;
  state_e            state_s;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W-1:0] ptr_inc_s;
  logic [1:0]        byte_idx_r;
  logic [WORD_W-1:0] word_r;
  logic              last_r;
  logic              overflow_r;

  // Pointer after the current word; wraps modulo MEM_BYTES since
  // MEM_BYTES == 2**ADDR_W. A result of zero means memory is full.
  assign ptr_inc_s = ptr_r + ADDR_W'(BYTES_PER_WORD);
  assign overflow  = overflow_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Session datapath: write pointer, byte counter, latched word and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r      <= '0;
      byte_idx_r <= 2'd0;
      word_r     <= '0;
      last_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            ptr_r      <= {base_addr[ADDR_W-1:2], 2'b00};
            overflow_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            word_r     <= in_word;
            last_r     <= in_last;
            byte_idx_r <= 2'd0;
          end
        end
        ST_WRITE: begin
          byte_idx_r <= byte_idx_r + 2'd1;
          if (byte_idx_r == 2'd3) begin
            ptr_r <= ptr_inc_s;
            // Set on entry to FIN so it is visible together with done.
            if ((ptr_inc_s == '0) && !last_r) begin
              overflow_r <= 1'b1;
            end
          end
        end
        default: begin
          ptr_r <= ptr_r;
        end
      endcase
    end
  end

  // Next-state and output decode of the registered state only.
  always_comb begin
    state_s   = state_r;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    busy      = 1'b0;
    cpu_stall = 1'b0;
    done      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // in_valid alongside start is ignored: in_ready is still 0 here.
        if (start) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        in_ready  = 1'b1;
        busy      = 1'b1;
        cpu_stall = 1'b1;
        if (in_valid) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = ptr_r + ADDR_W'(byte_idx_r);
        mem_wdata = byte_of(word_r, byte_idx_r);
        busy      = 1'b1;
        cpu_stall = 1'b1;
        if (byte_idx_r == 2'd3) begin
          if (last_r || (ptr_inc_s == '0)) begin
            state_s = ST_FIN;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven single-word sessions,
// hand-written multi-cycle corner cases and randomized sessions, all checked
// against a byte-level reference model of the memory image.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  base_addr;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_last;
  logic        in_ready;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        cpu_stall;
  logic        done;
  logic        overflow;

  imem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_word   (in_word),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .cpu_stall (cpu_stall),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed memory image and write count, captured at the write edge.
  bit [7:0] dut_mem [32];
  bit [7:0] exp_mem [32];
  int       we_cnt  = 0;
  int       exp_we  = 0;

  always @(posedge clk) begin
    if (mem_we) begin
      dut_mem[mem_addr] <= mem_wdata;
      we_cnt            <= we_cnt + 1;
    end
  end

  logic [31:0] wq [8];
  logic        lq [8];

  typedef struct {
    logic [4:0]  base;
    logic [31:0] word;
    logic        last;
    logic [4:0]  ebase;
    logic        eovf;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_cpu_stall"}, 32'(cpu_stall), 32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_overflow"},  32'(overflow),  32'd0);
  endtask

  // One load session from IDLE. Expectations: word k byte j lands at
  // (ebase + 4k + j) mod 32 with data byte j of the word; the session ends
  // after a word marked last or when the next word address wraps to 0.
  task automatic session(input logic [4:0] base, input logic [4:0] ebase, input int n,
                         input bit eovf, input bit hold, input bit vstart,
                         input bit sload, input bit sfin);
    logic [4:0] a;
    logic [7:0] b;
    bit         fin;
    int         cnt;
    start     = 1'b1;
    base_addr = base;
    if (vstart) begin
      in_valid = 1'b1;
      in_word  = wq[0];
      in_last  = lq[0];
    end
    @(negedge clk);
    start     = 1'b0;
    base_addr = 5'($urandom);
    chk("load_busy",  32'(busy),      32'd1);
    chk("load_stall", 32'(cpu_stall), 32'd1);
    chk("ovf_clear",  32'(overflow),  32'd0);
    chk("load_no_we", 32'(mem_we),    32'd0);
    if (sload) begin
      start     = 1'b1;
      base_addr = 5'd16;
      @(negedge clk);
      start = 1'b0;
      chk("sload_ready", 32'(in_ready), 32'd1);
    end
    fin = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_word  = wq[k];
      in_last  = lq[k];
      cnt = 0;
      while (!in_ready && cnt < 30) begin
        @(negedge clk);
        cnt++;
      end
      if (!in_ready) begin
        chk("ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
      if (!hold) in_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
        a = ebase + 5'(4 * k + j);
        b = 8'((wq[k] >> (8 * j)) & 32'hFF);
        chk("wr_we",    32'(mem_we),    32'd1);
        chk("wr_addr",  32'(mem_addr),  32'(a));
        chk("wr_data",  32'(mem_wdata), 32'(b));
        chk("wr_ready", 32'(in_ready),  32'd0);
        chk("wr_busy",  32'(busy),      32'd1);
        exp_mem[a] = b;
        exp_we++;
        @(negedge clk);
      end
      fin = lq[k] || ((ebase + 5'(4 * (k + 1))) == 5'd0);
      if (fin) begin
        chk("fin_done",  32'(done),      32'd1);
        chk("fin_busy",  32'(busy),      32'd0);
        chk("fin_stall", 32'(cpu_stall), 32'd0);
        chk("fin_we",    32'(mem_we),    32'd0);
        chk("fin_ovf",   32'(overflow),  32'(eovf));
        chk("fin_ready", 32'(in_ready),  32'd0);
        break;
      end else begin
        chk("next_ready", 32'(in_ready), 32'd1);
        chk("next_done",  32'(done),     32'd0);
      end
    end
    if (!fin) chk("session_end", 32'd0, 32'd1);
    in_valid = 1'b0;
    if (sfin) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("idle_done",  32'(done),     32'd0);
    chk("idle_busy",  32'(busy),     32'd0);
    chk("idle_ready", 32'(in_ready), 32'd0);
    chk("idle_ovf",   32'(overflow), 32'(eovf));
  endtask

  initial begin
    logic [4:0] rb;
    logic [4:0] reb;
    int         rn;
    bit         rovf;

    tbl[0] = '{5'd0,  32'h11090003, 1'b1, 5'd0,  1'b0};
    tbl[1] = '{5'd5,  32'hA1B2C3D4, 1'b1, 5'd4,  1'b0};
    tbl[2] = '{5'd28, 32'h08000000, 1'b1, 5'd28, 1'b0};
    tbl[3] = '{5'd31, 32'hDEADBEEF, 1'b0, 5'd28, 1'b1};
    tbl[4] = '{5'd18, 32'h01020304, 1'b1, 5'd16, 1'b0};

    rst_n = 1'b0; start = 1'b0; base_addr = 5'd0;
    in_valid = 1'b0; in_word = 32'd0; in_last = 1'b0;
    #1;
    chk_all_zero("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle_ready", 32'(in_ready), 32'd0);

    // Table-driven single-word sessions.
    for (int i = 0; i < 5; i++) begin
      wq[0] = tbl[i].word;
      lq[0] = tbl[i].last;
      session(tbl[i].base, tbl[i].ebase, 1, tbl[i].eovf, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Three words from an unaligned base, source holding in_valid throughout.
    wq[0] = 32'h11090003; wq[1] = 32'h112A0003; wq[2] = 32'h08000000;
    lq[0] = 1'b0; lq[1] = 1'b0; lq[2] = 1'b1;
    session(5'd5, 5'd4, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Overflow: no last word; start pulsed during FIN must be ignored.
    wq[0] = 32'hAAAA5555; wq[1] = 32'h12345678; wq[2] = 32'hFFFFFFFF;
    lq[0] = 1'b0; lq[1] = 1'b0; lq[2] = 1'b0;
    session(5'd24, 5'd24, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_no_accept", 32'(busy), 32'd0);

    // start during LOAD ignored (pointer must stay at 0).
    wq[0] = 32'h0BADF00D; lq[0] = 1'b1;
    session(5'd0, 5'd0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // start and in_valid together in IDLE: word is not taken on that edge.
    wq[0] = 32'h5A6B7C8D; lq[0] = 1'b1;
    session(5'd12, 5'd12, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized sessions against the address/overflow model.
    for (int r = 0; r < 10; r++) begin
      rb  = 5'($urandom);
      reb = rb & 5'b11100;
      if ($urandom_range(0, 1) == 0) begin
        rn = $urandom_range(1, 8);
        for (int k = 0; k < 8; k++) lq[k] = (k == rn - 1);
      end else begin
        rn = 8;
        for (int k = 0; k < 8; k++) lq[k] = 1'b0;
      end
      for (int k = 0; k < 8; k++) wq[k] = $urandom;
      rovf = 1'b0;
      for (int k = 0; k < rn; k++) begin
        if (lq[k]) break;
        if (((int'(reb) + 4 * (k + 1)) % 32) == 0) begin
          rovf = 1'b1;
          break;
        end
      end
      session(rb, reb, rn, rovf, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end

    // Reset in the middle of a word (third byte): first two bytes stay.
    wq[0] = 32'hCAFEF00D; lq[0] = 1'b1;
    start = 1'b1; base_addr = 5'd8;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_word = wq[0]; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    exp_mem[8] = 8'h0D; exp_mem[9] = 8'hF0; exp_we += 2;
    @(negedge clk);
    @(negedge clk);
    chk("mid_addr", 32'(mem_addr), 32'd10);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd0);
    chk("post_rst_busy",  32'(busy),     32'd0);

    // Whole memory image and write count.
    @(negedge clk);
    chk("we_count", 32'(we_cnt), 32'(exp_we));
    for (int i = 0; i < 32; i++) chk("mem_image", 32'(dut_mem[i]), 32'(exp_mem[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
